dc_fu_dma_line_scheduler: RTL and testbench

DC_FU_DMA_LINE_SCHEDULER -- requirements
Module: dc_fu_dma_line_scheduler

---
 rtl/dc_fu_dma_line_scheduler_if.sv | 26 ++
 rtl/dc_fu_dma_line_scheduler.sv | 138 +++++++++++++
 tb/tb_dc_fu_dma_line_scheduler.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dc_fu_dma_line_scheduler_if.sv
// AXI read-address / read-data control signals seen by the line scheduler.
// Valid/ready semantics: a transfer happens in a cycle where valid and ready are both 1;
// once valid is raised it stays high, with its qualifiers stable, until that transfer.
interface dc_fu_dma_line_scheduler_if;
  logic axi_arvalid;
  logic axi_arready;
  logic axi_rvalid;
  logic axi_rready;
  logic axi_rlast;

  modport master (
    output axi_arvalid,
    input  axi_arready,
    input  axi_rvalid,
    input  axi_rready,
    input  axi_rlast
  );

  modport slave (
    input  axi_arvalid,
    output axi_arready,
    output axi_rvalid,
    output axi_rready,
    output axi_rlast
  );
endinterface

// File: rtl/dc_fu_dma_line_scheduler.sv
// Per-frame line scheduler: waits for pixel FIFO room, kicks the address generator for
// each line, and throttles AR bursts so at most MAX_OUTSTANDING await their rlast.
module dc_fu_dma_line_scheduler #(
  parameter int AXI_ARADDR_WIDTH       = 32,
  parameter int FETCH_WORD_COUNT_WIDTH = 16,
  parameter int MAX_BURST_LEN          = 4,
  parameter int LINE_COUNT_WIDTH       = 12,
  parameter int MAX_OUTSTANDING        = 4
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic                                              en,
  input  logic                                              frame_start,
  input  logic [AXI_ARADDR_WIDTH-1:0]                       frame_base_addr,
  input  logic [AXI_ARADDR_WIDTH-1:0]                       line_stride,
  input  logic [LINE_COUNT_WIDTH-1:0]                       line_count,
  input  logic [FETCH_WORD_COUNT_WIDTH-1:0]                 line_word_count,
  input  logic [FETCH_WORD_COUNT_WIDTH-1:0]                 fifo_free_words,
  output logic                                              start_fetch,
  output logic [FETCH_WORD_COUNT_WIDTH-1:0]                 fetch_word_count,
  output logic [AXI_ARADDR_WIDTH-1:0]                       base_addr,
  input  logic [FETCH_WORD_COUNT_WIDTH-MAX_BURST_LEN-1:0]   trans_count,
  output logic                                              next_addr,
  dc_fu_dma_line_scheduler_if.master                        bus,
  output logic                                              busy,
  output logic                                              frame_done,
  output logic [LINE_COUNT_WIDTH-1:0]                       line_idx,
  output logic [2:0]                                        dbg_state,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]              dbg_outstanding
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OS = OW'(MAX_OUTSTANDING);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    START = 3'd2,
    ADDR  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t                            state;
  logic [OW-1:0]                     outstanding;
  logic [AXI_ARADDR_WIDTH-1:0]       stride_q;
  logic [LINE_COUNT_WIDTH-1:0]       lc_q;
  logic [FETCH_WORD_COUNT_WIDTH-1:0] wc_q;
  logic                              done_q;
  logic                              ar_hs;
  logic                              r_last_beat;
  logic                              os_inc;
  logic                              os_dec;

  // arvalid cannot drop before its handshake: trans_count only moves on next_addr and
  // outstanding only rises on next_addr, so the qualifiers hold while arvalid waits.
  assign bus.axi_arvalid = en && (state == ADDR) && (trans_count != '0) && (outstanding < MAX_OS);
  assign ar_hs           = bus.axi_arvalid && bus.axi_arready && en;
  assign next_addr       = ar_hs;
  assign r_last_beat     = bus.axi_rvalid && bus.axi_rready && bus.axi_rlast;

  assign os_inc = ar_hs;
  assign os_dec = r_last_beat && (outstanding != '0);

  assign start_fetch      = en && (state == START);
  assign frame_done       = en && done_q;
  assign busy             = (state != IDLE);
  assign fetch_word_count = wc_q;
  assign dbg_state        = state;
  assign dbg_outstanding  = outstanding;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      outstanding <= '0;
      line_idx    <= '0;
      base_addr   <= '0;
      stride_q    <= '0;
      lc_q        <= '0;
      wc_q        <= '0;
      done_q      <= 1'b0;
    end else if (en) begin
      done_q <= 1'b0;

      if (os_inc && !os_dec) begin
        outstanding <= outstanding + 1'b1;
      end else if (os_dec && !os_inc) begin
        outstanding <= outstanding - 1'b1;
      end

      case (state)
        IDLE: begin
          if (frame_start) begin
            base_addr <= frame_base_addr;
            stride_q  <= line_stride;
            lc_q      <= line_count;
            wc_q      <= line_word_count;
            line_idx  <= '0;
            // An empty frame completes immediately without touching the generator.
            if ((line_count == '0) || (line_word_count == '0)) begin
              done_q <= 1'b1;
            end else begin
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (fifo_free_words >= wc_q) begin
            state <= START;
          end
        end
        START: begin
          state <= ADDR;
        end
        ADDR: begin
          if (trans_count == '0) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (outstanding == '0) begin
            if (line_idx == lc_q - 1'b1) begin
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              line_idx  <= line_idx + 1'b1;
              base_addr <= base_addr + stride_q;
              state     <= CHECK;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dc_fu_dma_line_scheduler.sv
// Bench for dc_fu_dma_line_scheduler: frame-level vector table, directed corner
// sequences, then randomized frames checked against a line/burst scoreboard.
module tb_dc_fu_dma_line_scheduler;
  localparam int AW  = 32;
  localparam int FW  = 16;
  localparam int MBL = 4;
  localparam int LCW = 12;
  localparam int MO  = 4;
  localparam int OW  = $clog2(MO + 1);
  localparam int TW  = FW - MBL;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic            en = 1'b1;
  logic            frame_start = 1'b0;
  logic [AW-1:0]   frame_base_addr = '0;
  logic [AW-1:0]   line_stride = '0;
  logic [LCW-1:0]  line_count = '0;
  logic [FW-1:0]   line_word_count = '0;
  logic [FW-1:0]   fifo_free_words;
  logic            start_fetch;
  logic [FW-1:0]   fetch_word_count;
  logic [AW-1:0]   base_addr;
  logic [TW-1:0]   trans_count = '0;
  logic            next_addr;
  logic            busy;
  logic            frame_done;
  logic [LCW-1:0]  line_idx;
  logic [2:0]      dbg_state;
  logic [OW-1:0]   dbg_outstanding;

  dc_fu_dma_line_scheduler_if bus ();

  dc_fu_dma_line_scheduler #(
    .AXI_ARADDR_WIDTH(AW), .FETCH_WORD_COUNT_WIDTH(FW), .MAX_BURST_LEN(MBL),
    .LINE_COUNT_WIDTH(LCW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .frame_start(frame_start),
    .frame_base_addr(frame_base_addr), .line_stride(line_stride),
    .line_count(line_count), .line_word_count(line_word_count),
    .fifo_free_words(fifo_free_words), .start_fetch(start_fetch),
    .fetch_word_count(fetch_word_count), .base_addr(base_addr),
    .trans_count(trans_count), .next_addr(next_addr), .bus(bus),
    .busy(busy), .frame_done(frame_done), .line_idx(line_idx),
    .dbg_state(dbg_state), .dbg_outstanding(dbg_outstanding)
  );

  // ---------------- stimulus sources ----------------
  logic         ar_rand = 1'b0, ar_man = 1'b1, ar_rnd = 1'b1;
  logic         ff_rand = 1'b0;
  logic [FW-1:0] ff_man = 16'hFFFF, ff_rnd = '0;
  logic         man_rlast = 1'b0, auto_rlast = 1'b0, data_beat = 1'b0;
  bit           rl_hold = 1'b0, rand_beats = 1'b0;
  int           lat_min = 3, lat_max = 3;
  int           cyc = 0;
  int           due_q[$];

  assign bus.axi_arready = ar_rand ? ar_rnd : ar_man;
  assign bus.axi_rvalid  = auto_rlast | man_rlast | data_beat;
  assign bus.axi_rlast   = auto_rlast | man_rlast;
  assign bus.axi_rready  = 1'b1;
  assign fifo_free_words = ff_rand ? ff_rnd : ff_man;

  // Address generator stand-in: bursts = ceil(words / 2^MBL), one consumed per next_addr.
  always @(posedge clk) begin
    if (rst) trans_count <= '0;
    else if (start_fetch) trans_count <= TW'((int'(fetch_word_count) + (1 << MBL) - 1) >> MBL);
    else if (next_addr && trans_count != '0) trans_count <= trans_count - 1'b1;
  end

  // Read responder: returns each burst's rlast a latency after its AR handshake.
  always @(posedge clk) begin
    cyc = cyc + 1;
    ar_rnd <= ($urandom_range(9, 0) < 7);
    ff_rnd <= FW'($urandom_range(80, 0));
    if (rst) begin
      due_q.delete();
      auto_rlast <= 1'b0;
      data_beat  <= 1'b0;
    end else begin
      if (next_addr) due_q.push_back(cyc + $urandom_range(lat_max, lat_min));
      auto_rlast <= 1'b0;
      data_beat  <= 1'b0;
      if (!rl_hold && due_q.size() != 0 && due_q[0] <= cyc) begin
        auto_rlast <= 1'b1;
        void'(due_q.pop_front());
      end else if (rand_beats) begin
        data_beat <= ($urandom_range(3, 0) == 0);
      end
    end
  end

  // ---------------- checking ----------------
  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  int            n_start = 0, n_hs = 0, n_done = 0;
  logic [AW-1:0] last_base = '0;
  int            tb_out = 0;
  bit            sb_on = 1'b0, line_open = 1'b0;
  int            line_hs = 0, exp_hs = 0;
  logic [FW-1:0] exp_wc = '0;
  logic [AW-1:0] exp_q[$];

  // Samples on the falling edge; handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      tb_out = 0;
    end else begin
      if (sb_on) begin
        check("sb_outstanding", 64'(dbg_outstanding), 64'(tb_out));
        if (bus.axi_arvalid) check("sb_arvalid_bound", 64'(tb_out < MO), 64'd1);
        if (start_fetch) begin
          if (exp_q.size() == 0) check("sb_unexpected_start", 64'd1, 64'd0);
          else begin
            check("sb_base", 64'(base_addr), 64'(exp_q.pop_front()));
            check("sb_wc", 64'(fetch_word_count), 64'(exp_wc));
          end
          if (line_open) check("sb_line_hs", 64'(line_hs), 64'(exp_hs));
          line_hs = 0;
          line_open = 1'b1;
        end
        if (next_addr) line_hs++;
        if (frame_done) begin
          if (line_open) check("sb_line_hs", 64'(line_hs), 64'(exp_hs));
          line_open = 1'b0;
          check("sb_lines_left", 64'(exp_q.size()), 64'd0);
        end
      end
      if (start_fetch) begin n_start++; last_base = base_addr; end
      if (next_addr) n_hs++;
      if (frame_done) n_done++;
      if (en) tb_out = tb_out + (next_addr ? 1 : 0) - ((bus.axi_rlast && bus.axi_rvalid && tb_out > 0) ? 1 : 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int d0, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (n_done != d0) seen = 1'b1;
    end
    check(nm, 64'(seen), 64'd1);
  endtask

  task automatic kick(input logic [AW-1:0] b, input logic [AW-1:0] s,
                      input logic [LCW-1:0] lc, input logic [FW-1:0] wc);
    @(posedge clk); #1;
    frame_base_addr = b; line_stride = s; line_count = lc; line_word_count = wc;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  typedef struct {
    logic [AW-1:0]  base;
    logic [AW-1:0]  stride;
    logic [LCW-1:0] lc;
    logic [FW-1:0]  wc;
    int             n_start;
    int             n_hs;
    logic [AW-1:0]  last_base;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int s0, h0, d0;
    tbl[0] = '{32'h0000_1000, 32'h0000_0800, 12'd2, 16'd32, 2, 4, 32'h0000_1800};
    tbl[1] = '{32'h0000_2000, 32'h0000_0100, 12'd0, 16'd16, 0, 0, 32'h0};
    tbl[2] = '{32'h0000_3000, 32'h0000_0100, 12'd3, 16'd0,  0, 0, 32'h0};
    tbl[3] = '{32'h0000_2000, 32'h0000_0400, 12'd1, 16'd17, 1, 2, 32'h0000_2000};
    tbl[4] = '{32'hFFFF_F000, 32'h0000_0800, 12'd3, 16'd48, 3, 9, 32'h0000_0000};
    tbl[5] = '{32'h0000_0000, 32'h0000_0040, 12'd4, 16'd16, 4, 4, 32'h0000_00C0};

    // Reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_line_idx", 64'(line_idx), 64'd0);
    check("rst_base", 64'(base_addr), 64'd0);
    check("rst_fwc", 64'(fetch_word_count), 64'd0);
    check("rst_outstanding", 64'(dbg_outstanding), 64'd0);
    check("rst_pulses", 64'({start_fetch, next_addr, bus.axi_arvalid, frame_done}), 64'd0);

    // Frame-level vector table.
    foreach (tbl[k]) begin
      s0 = n_start; h0 = n_hs; d0 = n_done;
      kick(tbl[k].base, tbl[k].stride, tbl[k].lc, tbl[k].wc);
      wait_done(d0, $sformatf("tbl%0d_done_seen", k));
      repeat (2) @(negedge clk);
      check($sformatf("tbl%0d_starts", k), 64'(n_start - s0), 64'(tbl[k].n_start));
      check($sformatf("tbl%0d_handshakes", k), 64'(n_hs - h0), 64'(tbl[k].n_hs));
      check($sformatf("tbl%0d_dones", k), 64'(n_done - d0), 64'd1);
      check($sformatf("tbl%0d_busy_after", k), 64'(busy), 64'd0);
      if (tbl[k].n_start != 0) check($sformatf("tbl%0d_last_base", k), 64'(last_base), 64'(tbl[k].last_base));
    end

    // Empty frame: frame_done exactly one cycle after frame_start, never busy.
    s0 = n_start;
    kick(32'h5000, 32'h10, 12'd0, 16'd16);
    @(negedge clk);
    check("empty_done_pulse", 64'(frame_done), 64'd1);
    check("empty_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("empty_done_once", 64'(frame_done), 64'd0);
    check("empty_no_start", 64'(n_start - s0), 64'd0);

    // FIFO gating: stay in CHECK until 16 words are free; stray frame_start ignored.
    ff_man = 16'd10;
    s0 = n_start; d0 = n_done;
    kick(32'h4000, 32'h100, 12'd1, 16'd16);
    repeat (5) @(negedge clk);
    check("gate_busy", 64'(busy), 64'd1);
    check("gate_state", 64'(dbg_state), 64'(S_CHECK));
    check("gate_no_start", 64'(n_start - s0), 64'd0);
    kick(32'h9999, 32'h1, 12'd7, 16'd1);
    @(negedge clk);
    check("ignore_frame_start", 64'(base_addr), 64'h4000);
    @(posedge clk); #1 ff_man = 16'd16;
    @(negedge clk);
    check("gate_not_yet", 64'(start_fetch), 64'd0);
    @(posedge clk); @(negedge clk);
    check("gate_start_after_raise", 64'(start_fetch), 64'd1);
    wait_done(d0, "gate_done_seen");
    ff_man = 16'hFFFF;

    // Outstanding limit with rlast withheld: 4 handshakes, then one per returned rlast.
    rl_hold = 1'b1;
    h0 = n_hs; d0 = n_done;
    kick(32'h8000, 32'h0, 12'd1, 16'd96);
    repeat (12) @(negedge clk);
    check("limit_hs4", 64'(n_hs - h0), 64'd4);
    check("limit_arvalid_low", 64'(bus.axi_arvalid), 64'd0);
    check("limit_outstanding", 64'(dbg_outstanding), 64'(MO));
    @(posedge clk); #1 man_rlast = 1'b1;
    if (due_q.size() != 0) void'(due_q.pop_front());
    @(posedge clk); #1 man_rlast = 1'b0;
    repeat (6) @(negedge clk);
    check("limit_hs5", 64'(n_hs - h0), 64'd5);
    check("limit_arvalid_low2", 64'(bus.axi_arvalid), 64'd0);
    rl_hold = 1'b0;
    wait_done(d0, "limit_done_seen");
    check("limit_hs_total", 64'(n_hs - h0), 64'd6);

    // arvalid holding, en freeze, simultaneous AR + rlast, then reset mid-ADDR.
    rl_hold = 1'b1; ar_man = 1'b0;
    h0 = n_hs; d0 = n_done;
    kick(32'hA000, 32'h0, 12'd1, 16'd96);
    for (int i = 0; i < 20 && dbg_state != S_ADDR; i++) @(negedge clk);
    check("reach_addr", 64'(dbg_state), 64'(S_ADDR));
    check("arvalid_waits", 64'(bus.axi_arvalid), 64'd1);
    @(posedge clk); #1 en = 1'b0; ar_man = 1'b1;
    @(negedge clk);
    check("en0_arvalid", 64'(bus.axi_arvalid), 64'd0);
    check("en0_next_addr", 64'(next_addr), 64'd0);
    @(posedge clk); #1 en = 1'b1;
    @(negedge clk);
    check("en0_frozen_os", 64'(dbg_outstanding), 64'd0);
    check("en0_frozen_state", 64'(dbg_state), 64'(S_ADDR));
    @(posedge clk); @(posedge clk); #1 ar_man = 1'b0;
    @(negedge clk);
    check("os_two", 64'(dbg_outstanding), 64'd2);
    @(posedge clk); #1 ar_man = 1'b1; man_rlast = 1'b1;
    if (due_q.size() != 0) void'(due_q.pop_front());
    @(negedge clk);
    check("same_cycle_hs", 64'(next_addr), 64'd1);
    @(posedge clk); #1 ar_man = 1'b0; man_rlast = 1'b0;
    @(negedge clk);
    check("same_cycle_os", 64'(dbg_outstanding), 64'd2);
    @(posedge clk); #1 ar_man = 1'b1;
    @(posedge clk); #1 ar_man = 1'b0;
    @(negedge clk);
    check("os_three", 64'(dbg_outstanding), 64'd3);
    check("hs_count_before_rst", 64'(n_hs - h0), 64'd4);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_addr_busy", 64'(busy), 64'd0);
    check("rst_addr_os", 64'(dbg_outstanding), 64'd0);
    check("rst_addr_arvalid", 64'(bus.axi_arvalid), 64'd0);
    check("rst_addr_base", 64'(base_addr), 64'd0);
    @(posedge clk); #1 man_rlast = 1'b1;
    @(posedge clk); #1 man_rlast = 1'b0;
    repeat (3) @(negedge clk);
    check("late_rlast_os", 64'(dbg_outstanding), 64'd0);
    check("late_rlast_state", 64'(dbg_state), 64'(S_IDLE));
    check("late_rlast_no_done", 64'(n_done - d0), 64'd0);
    rl_hold = 1'b0; ar_man = 1'b1;

    // Randomized frames against the line/burst scoreboard.
    ar_rand = 1'b1; ff_rand = 1'b1; rand_beats = 1'b1;
    lat_min = 1; lat_max = 6;
    sb_on = 1'b1;
    for (int f = 0; f < 25; f++) begin
      logic [AW-1:0]  b, s;
      logic [LCW-1:0] lc;
      logic [FW-1:0]  wc;
      b  = $urandom;
      s  = $urandom;
      lc = LCW'($urandom_range(3, 0));
      wc = ($urandom_range(3, 0) == 0) ? 16'd0 : FW'($urandom_range(70, 1));
      exp_wc = wc;
      exp_hs = (int'(wc) + 15) / 16;
      if (lc != 0 && wc != 0)
        for (int i = 0; i < int'(lc); i++) exp_q.push_back(b + AW'(i) * s);
      d0 = n_done;
      kick(b, s, lc, wc);
      wait_done(d0, $sformatf("rnd%0d_done_seen", f));
      @(negedge clk);
    end
    sb_on = 1'b0;
    check("rnd_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
